word_2_byte: RTL and testbench
==============================

Name: word_2_byte

Overview:
- Splits 16-bit words into two bytes for the UART transmit path. It is the transmit-side counterpart of the receive-side byte-to-word assembler.
- Byte order matches the assembler: the first byte sent is word[7:0] and the second is word[15:8]. A word packed by this block is therefore rebuilt unchanged at the far end.
- A valid/ready handshake is used on both sides. A one-word holding register lets the next word be accepted while the current one is being sent.

Parameters:
- GAP_CYCLES, 0, number of ce-enabled idle cycles inserted after each accepted byte before the next byte_dv is asserted (0 = back-to-back bytes).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the clk edge); not gated by ce.
- ce  input  1  clock enable; state and outputs advance only when ce=1.
- word_dv  input  1  upstream word valid.
- word  input  16  upstream word; sampled when accepted.
- word_ready  output  1  block can accept a word this cycle.
- byte_ready  input  1  UART TX can accept a byte this cycle.
- byte_dv  output  1  byteee holds a valid byte for the TX.
- byteee  output  8  byte to transmit.
- busy  output  1  a word is in flight or held.

Behaviour:
- Handshakes:
  - Word accept = word_dv & word_ready & ce.
  - Byte accept = byte_dv & byte_ready & ce.
- ce=0 freezes all registers. Outputs hold their values and no accept occurs on either side.
- Registers:
  - cur[15:0]: word being sent.
  - hold[15:0] with hold_valid: the one-entry holding register.
  - FSM state.
  - Gap counter, width clog2(GAP_CYCLES+1), minimum 1 bit.
- word_ready is combinational from registers:
  - word_ready = rst & ~hold_valid.
  - word_ready must not depend on word_dv or byte_ready.
- FSM states IDLE, LO, GAP, HI:
  - IDLE: byte_dv=0. On word accept, cur<=word, go to LO. byte_dv=1 in the next cycle (latency 1 cycle, ce permitting).
  - LO: byte_dv=1, byteee=cur[7:0]. On byte accept, go to GAP if GAP_CYCLES>0 (counter loaded with GAP_CYCLES-1, return target HI); otherwise go straight to HI.
  - HI: byte_dv=1, byteee=cur[15:8]. On byte accept:
    - if hold_valid: cur<=hold, hold_valid<=0, next byte is LO (via GAP if GAP_CYCLES>0);
    - else if word accepted this same cycle: cur<=word, next byte is LO (via GAP if GAP_CYCLES>0);
    - otherwise go to IDLE.
  - GAP: byte_dv=0. The counter decrements on each ce cycle. At 0, go to the stored target (HI, or LO for a new word).
  - GAP_CYCLES applies between words as well as between the two bytes of a word.
- Word accept while state is LO, GAP or HI goes into hold (hold_valid<=1). The one exception is the HI-accept case above, where the word goes directly to cur.
- byte_dv and byteee are registered. While byte_dv=1 and byte_ready=0, both must remain stable.
- busy = (state != IDLE) | hold_valid.
- Reset (rst=0 at clk edge):
  - state=IDLE, byte_dv=0, byteee=8'h00, hold_valid=0, cur=0, hold=0, gap counter=0.
  - word_ready=0 while rst=0.
  - Reset mid-operation discards the in-flight word and the held word. No partial byte follows reset.
- No overflow is possible: the upstream must honour word_ready. A word_dv asserted while word_ready=0 is ignored and not captured.

Test Plan:
- Single word, GAP_CYCLES=0, byte_ready=1, ce=1:
  - stimulus: word=16'hA55A accepted at cycle 0;
  - required: byte_dv=1 with byteee=8'h5A in cycle 1, then 8'hA5 in cycle 2, byte_dv=0 and busy=0 in cycle 3.
- Back-pressure:
  - stimulus: byte_ready held 0 for 5 cycles during the LO byte of 16'h1234;
  - required: byteee stays 8'h34 with byte_dv=1; after release, 8'h12 follows; no byte is dropped or duplicated.
- Streaming, byte_ready=1:
  - stimulus: words 16'h0102, 16'h0304, 16'h0506 with word_dv held high;
  - required: word_ready deasserts when hold fills; bytes appear as 02,01,04,03,06,05 contiguously.
- GAP_CYCLES=3:
  - stimulus: word 16'hBEEF;
  - required: byte EF, then exactly 3 ce cycles with byte_dv=0, then byte BE.
- ce toggling 1-of-4, same stimulus as the first scenario:
  - required: identical byte sequence; nothing changes while ce=0; no accept occurs while ce=0.
- Reset mid-word:
  - stimulus: rst=0 for one edge after the LO byte of 16'hCAFE is accepted, with a second word held;
  - required: byte_dv=0, busy=0, word_ready=1 after reset; 16'hCA is never emitted.

Source files
------------

// File: rtl/word_2_byte.sv
// word_2_byte: splits 16-bit words into two bytes (low byte first) for the
// UART transmit path, with a one-word holding register so the next word can be
// accepted while the current one is being sent.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-low reset, not gated by ce
//   ce         clock enable; nothing advances while ce=0
//   word_dv    upstream word valid
//   word       upstream word, captured on accept
//   word_ready block can accept a word (derived from registers and rst only)
//   byte_ready downstream TX can accept a byte
//   byte_dv    byteee holds a valid byte (registered)
//   byteee     byte to transmit (registered)
//   busy       a word is in flight or held
module word_2_byte #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        word_dv,
  input  logic [15:0] word,
  output logic        word_ready,
  input  logic        byte_ready,
  output logic        byte_dv,
  output logic [7:0]  byteee,
  output logic        busy
);

  localparam int unsigned CNT_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic        HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_GAP  = 2'd2,
    ST_HI   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cur_q, cur_d;
  logic [15:0]      hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_hi_q, tgt_hi_d;
  logic             byte_dv_q, byte_dv_d;
  logic [7:0]       byteee_q, byteee_d;

  logic word_acc;
  logic byte_acc;

  // Ready depends only on registers and reset, never on word_dv/byte_ready.
  assign word_ready = rst & ~hold_valid_q;
  assign word_acc   = word_dv & word_ready & ce;
  assign byte_acc   = byte_dv_q & byte_ready & ce;

  assign byte_dv = byte_dv_q;
  assign byteee  = byteee_q;
  assign busy    = (state_q != ST_IDLE) | hold_valid_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    cnt_d        = cnt_q;
    tgt_hi_d     = tgt_hi_q;

    // Words arriving while a word is in flight go to the holding register,
    // except when the high byte leaves in the same cycle (handled in ST_HI).
    if (word_acc && (state_q != ST_IDLE) && !((state_q == ST_HI) && byte_acc)) begin
      hold_d       = word;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (word_acc) begin
          cur_d   = word;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (byte_acc) begin
          if (HAS_GAP) begin
            state_d  = ST_GAP;
            cnt_d    = GAP_LOAD;
            tgt_hi_d = 1'b1;
          end else begin
            state_d = ST_HI;
          end
        end
      end
      ST_GAP: begin
        if (ce) begin
          if (cnt_q == '0) begin
            state_d = tgt_hi_q ? ST_HI : ST_LO;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_HI: begin
        if (byte_acc) begin
          if (hold_valid_q || word_acc) begin
            cur_d        = hold_valid_q ? hold_q : word;
            hold_valid_d = 1'b0;
            if (HAS_GAP) begin
              state_d  = ST_GAP;
              cnt_d    = GAP_LOAD;
              tgt_hi_d = 1'b0;
            end else begin
              state_d = ST_LO;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte outputs follow the next state so they are valid in the cycle the
    // state is entered; they cannot change while a byte is pending.
    byte_dv_d = (state_d == ST_LO) || (state_d == ST_HI);
    byteee_d  = byteee_q;
    if (state_d == ST_LO) begin
      byteee_d = cur_d[7:0];
    end else if (state_d == ST_HI) begin
      byteee_d = cur_d[15:8];
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
      tgt_hi_q     <= 1'b0;
      byte_dv_q    <= 1'b0;
      byteee_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
      tgt_hi_q     <= tgt_hi_d;
      byte_dv_q    <= byte_dv_d;
      byteee_q     <= byteee_d;
    end
  end

endmodule

// File: tb/tb_word_2_byte.sv
// Directed self-checking bench for word_2_byte: one instance with no gap and
// one with GAP_CYCLES=3 sharing clock, reset, ce and byte_ready.
module tb_word_2_byte;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        byte_ready;

  logic        word_dv;
  logic [15:0] word;
  logic        word_ready;
  logic        byte_dv;
  logic [7:0]  byteee;
  logic        busy;

  logic        g_word_dv;
  logic [15:0] g_word;
  logic        g_word_ready;
  logic        g_byte_dv;
  logic [7:0]  g_byteee;
  logic        g_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  word_2_byte #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .word_dv(word_dv), .word(word), .word_ready(word_ready),
    .byte_ready(byte_ready), .byte_dv(byte_dv), .byteee(byteee), .busy(busy)
  );

  word_2_byte #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .ce(ce),
    .word_dv(g_word_dv), .word(g_word), .word_ready(g_word_ready),
    .byte_ready(byte_ready), .byte_dv(g_byte_dv), .byteee(g_byteee), .busy(g_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streaming expectations per cycle for words 0102, 0304, 0506.
  logic [7:0]  s_byte [0:7];
  logic        s_dv   [0:7];
  logic        s_rdy  [0:7];
  logic [15:0] s_word [0:2];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic acc;
    logic done;

    s_byte = '{8'h00, 8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'h00};
    s_dv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    s_rdy  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    s_word = '{16'h0102, 16'h0304, 16'h0506};

    rst = 1'b0; ce = 1'b1; byte_ready = 1'b1;
    word_dv = 1'b0; word = 16'h0000;
    g_word_dv = 1'b0; g_word = 16'h0000;

    // Reset state
    step(); step();
    check("rst_byte_dv", 32'(byte_dv), 32'd0);
    check("rst_byteee", 32'(byteee), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_ready", 32'(word_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_word_ready", 32'(word_ready), 32'd1);

    // Single word A55A, back-to-back bytes
    word = 16'hA55A; word_dv = 1'b1;
    step();
    word_dv = 1'b0;
    check("single_c1_dv", 32'(byte_dv), 32'd1);
    check("single_c1_byte", 32'(byteee), 32'h5A);
    step();
    check("single_c2_dv", 32'(byte_dv), 32'd1);
    check("single_c2_byte", 32'(byteee), 32'hA5);
    step();
    check("single_c3_dv", 32'(byte_dv), 32'd0);
    check("single_c3_busy", 32'(busy), 32'd0);

    // Back-pressure on the low byte of 1234
    word = 16'h1234; word_dv = 1'b1; byte_ready = 1'b0;
    step();
    word_dv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_dv", 32'(byte_dv), 32'd1);
      check("bp_hold_byte", 32'(byteee), 32'h34);
      step();
    end
    byte_ready = 1'b1;
    check("bp_release_byte", 32'(byteee), 32'h34);
    step();
    check("bp_hi_dv", 32'(byte_dv), 32'd1);
    check("bp_hi_byte", 32'(byteee), 32'h12);
    step();
    check("bp_end_dv", 32'(byte_dv), 32'd0);
    check("bp_end_busy", 32'(busy), 32'd0);

    // Streaming with word_dv held high while words remain
    w = 0;
    for (int c = 0; c < 8; c++) begin
      word_dv = (w < 3);
      word    = (w < 3) ? s_word[w] : 16'h0000;
      check("stream_word_ready", 32'(word_ready), 32'(s_rdy[c]));
      check("stream_dv", 32'(byte_dv), 32'(s_dv[c]));
      if (s_dv[c]) check("stream_byte", 32'(byteee), 32'(s_byte[c]));
      acc = word_dv & word_ready;
      step();
      if (acc) w++;
    end
    word_dv = 1'b0;
    check("stream_words_taken", 32'(w), 32'd3);

    // GAP_CYCLES=3 instance, word BEEF
    g_word = 16'hBEEF; g_word_dv = 1'b1;
    step();
    g_word_dv = 1'b0;
    check("gap_lo_dv", 32'(g_byte_dv), 32'd1);
    check("gap_lo_byte", 32'(g_byteee), 32'hEF);
    step();
    for (int i = 0; i < 3; i++) begin
      check("gap_idle_dv", 32'(g_byte_dv), 32'd0);
      check("gap_idle_busy", 32'(g_busy), 32'd1);
      step();
    end
    check("gap_hi_dv", 32'(g_byte_dv), 32'd1);
    check("gap_hi_byte", 32'(g_byteee), 32'hBE);
    step();
    check("gap_end_dv", 32'(g_byte_dv), 32'd0);
    check("gap_end_busy", 32'(g_busy), 32'd0);

    // ce active one cycle in four, word A55A
    done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      ce      = ((k % 4) == 3);
      word_dv = ~done;
      word    = 16'hA55A;
      check("ce_dv", 32'(byte_dv), (k >= 4 && k < 12) ? 32'd1 : 32'd0);
      check("ce_busy", 32'(busy), (k >= 4 && k < 12) ? 32'd1 : 32'd0);
      if (k >= 4 && k < 12)
        check("ce_byte", 32'(byteee), (k < 8) ? 32'h5A : 32'hA5);
      acc = word_dv & word_ready & ce;
      step();
      if (acc) done = 1'b1;
    end
    ce = 1'b1; word_dv = 1'b0;

    // Reset after the low byte of CAFE leaves, with a second word held
    word = 16'hCAFE; word_dv = 1'b1;
    step();
    word = 16'h1111;
    check("rstmid_lo_byte", 32'(byteee), 32'hFE);
    step();
    word_dv = 1'b0; byte_ready = 1'b0;
    check("rstmid_hi_byte", 32'(byteee), 32'hCA);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    check("rstmid_ready_held", 32'(word_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rstmid_ready_in_rst", 32'(word_ready), 32'd0);
    step();
    rst = 1'b1; byte_ready = 1'b1;
    #1;
    check("rstmid_dv", 32'(byte_dv), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(word_ready), 32'd1);
    check("rstmid_byteee", 32'(byteee), 32'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstmid_quiet_dv", 32'(byte_dv), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
